// File: rtl/mips_datapath_if.sv
// Unified memory port between the multi-cycle datapath and a combinational-read memory.
interface mips_datapath_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        read;
  logic        write;

  modport master (output addr, wdata, read, write, input rdata);
  modport slave  (input addr, wdata, read, write, output rdata);
endinterface

// File: rtl/mips_datapath.sv
// Multi-cycle MIPS-subset datapath: PC, IR, MDR, A/B, ALUOut, link register and 32x32 register file.
// All sequencing comes from the external controller; this block only decodes op/funct for it.
module mips_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pcen,
  input  logic             irwrite,
  input  logic             iord,
  input  logic             regwrite,
  input  logic             alusrca,
  input  logic             memread,
  input  logic             memwrite,
  input  logic [1:0]       pcsource,
  input  logic [1:0]       alusrcb,
  input  logic [1:0]       aluop,
  input  logic [1:0]       memtoreg,
  input  logic [1:0]       regdst,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic             zero,
  output logic [31:0]      pc_dbg,
  mips_datapath_if.master  mem
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] aluout_q, aluout_d;
  logic [31:0] link_q, link_d;
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];

  logic [4:0]  rs, rt, rd, wr_addr;
  logic [15:0] imm;
  logic [31:0] signimm, zeroimm, luiimm;
  logic [31:0] src_a, src_b, alu_y, pc_next, wr_data, rd1, rd2;

  assign op      = ir_q[31:26];
  assign funct   = ir_q[5:0];
  assign rs      = ir_q[25:21];
  assign rt      = ir_q[20:16];
  assign rd      = ir_q[15:11];
  assign imm     = ir_q[15:0];
  assign signimm = {{16{imm[15]}}, imm};
  assign zeroimm = {16'h0000, imm};
  assign luiimm  = {imm, 16'h0000};

  // Reads see only committed state, so a same-cycle write is visible one cycle later.
  assign rd1 = (rs == 5'd0) ? 32'h0 : rf_q[rs];
  assign rd2 = (rt == 5'd0) ? 32'h0 : rf_q[rt];

  assign src_a = alusrca ? a_q : pc_q;

  always_comb begin
    case (alusrcb)
      2'b00:   src_b = b_q;
      2'b01:   src_b = 32'd4;
      2'b10:   src_b = (op == 6'b001101) ? zeroimm : signimm;
      default: src_b = (op == 6'b001111) ? luiimm : {signimm[29:0], 2'b00};
    endcase
  end

  always_comb begin
    alu_y = src_a + src_b;
    case (aluop)
      2'b01: alu_y = src_a - src_b;
      2'b11: alu_y = src_a | src_b;
      2'b10: begin
        case (funct)
          6'b100010: alu_y = src_a - src_b;
          6'b100100: alu_y = src_a & src_b;
          6'b100101: alu_y = src_a | src_b;
          6'b101010: alu_y = {31'b0, ($signed(src_a) < $signed(src_b))};
          default:   alu_y = src_a + src_b;
        endcase
      end
      default: alu_y = src_a + src_b;
    endcase
  end

  assign zero = (alu_y == 32'h0);

  always_comb begin
    case (pcsource)
      2'b00:   pc_next = alu_y;
      2'b01:   pc_next = aluout_q;
      2'b10:   pc_next = {pc_q[31:28], ir_q[25:0], 2'b00};
      default: pc_next = a_q;
    endcase
  end

  // Link captures PC+4 during fetch so JAL can write it back independent of memtoreg.
  always_comb begin
    case (regdst)
      2'b01:   wr_addr = rd;
      2'b10:   wr_addr = 5'd31;
      default: wr_addr = rt;
    endcase
    if (regdst == 2'b10)
      wr_data = link_q;
    else if (memtoreg == 2'b01)
      wr_data = mdr_q;
    else
      wr_data = aluout_q;
  end

  always_comb begin
    pc_d     = pcen ? pc_next : pc_q;
    ir_d     = irwrite ? mem.rdata : ir_q;
    link_d   = irwrite ? alu_y : link_q;
    mdr_d    = mem.rdata;
    a_d      = rd1;
    b_d      = rd2;
    aluout_d = alu_y;
    rf_d     = rf_q;
    if (regwrite && (wr_addr != 5'd0))
      rf_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      mdr_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      link_q   <= '0;
      for (int i = 0; i < 32; i++)
        rf_q[i] <= '0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      mdr_q    <= mdr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
      link_q   <= link_d;
      for (int i = 0; i < 32; i++)
        rf_q[i] <= rf_d[i];
    end
  end

  assign mem.addr  = iord ? aluout_q : pc_q;
  assign mem.wdata = b_q;
  assign mem.read  = memread;
  assign mem.write = memwrite;
  assign pc_dbg    = pc_q;

endmodule

// File: tb/tb_mips_datapath.sv
// Bench for mips_datapath: plays the controller's state sequence per instruction and
// compares against an instruction-level model of the MIPS subset.
module tb_mips_datapath;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pcen = 0, irwrite = 0, iord = 0, regwrite = 0, alusrca = 0;
  logic        memread = 0, memwrite = 0;
  logic [1:0]  pcsource = 0, alusrcb = 0, aluop = 0, memtoreg = 0, regdst = 0;
  logic [5:0]  op, funct;
  logic        zero;
  logic [31:0] pc_dbg;

  mips_datapath_if bus ();
  logic [31:0] mem [1024];
  assign bus.rdata = mem[bus.addr[11:2]];

  mips_datapath #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset_n(reset_n), .pcen(pcen), .irwrite(irwrite), .iord(iord),
    .regwrite(regwrite), .alusrca(alusrca), .memread(memread), .memwrite(memwrite),
    .pcsource(pcsource), .alusrcb(alusrcb), .aluop(aluop), .memtoreg(memtoreg),
    .regdst(regdst), .op(op), .funct(funct), .zero(zero), .pc_dbg(pc_dbg), .mem(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_reg [32];
  logic [31:0] m_mem [1024];
  logic [31:0] m_pc;

  logic        obs_zero, obs_write;
  logic [31:0] obs_addr, obs_wdata, obs_fetch_addr;

  typedef enum {S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_REXEC,
                S_RWB, S_BRANCH, S_ADDI, S_ORI, S_LUI, S_ALUWB, S_JUMP, S_JALWB, S_JR} st_t;

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] s,
                                        input logic [4:0] t, input logic [4:0] d);
    return {6'h00, s, t, d, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] o, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] im);
    return {o, s, t, im};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] o, input logic [25:0] tg);
    return {o, tg};
  endfunction

  // Applies one controller state, then clocks one edge; returns at posedge+1.
  task automatic ctrl(input st_t s);
    pcen = 0; irwrite = 0; iord = 0; regwrite = 0; alusrca = 0; memread = 0; memwrite = 0;
    pcsource = 2'b00; alusrcb = 2'b00; aluop = 2'b00; memtoreg = 2'b00; regdst = 2'b00;
    case (s)
      S_FETCH:    begin memread = 1; irwrite = 1; alusrcb = 2'b01; pcen = 1; end
      S_DECODE:   alusrcb = 2'b11;
      S_MEMADR:   begin alusrca = 1; alusrcb = 2'b10; end
      S_MEMREAD:  begin iord = 1; memread = 1; end
      S_MEMWB:    begin regwrite = 1; memtoreg = 2'b01; end
      S_MEMWRITE: begin iord = 1; memwrite = 1; end
      S_REXEC:    begin alusrca = 1; aluop = 2'b10; end
      S_RWB:      begin regwrite = 1; regdst = 2'b01; end
      S_BRANCH:   begin alusrca = 1; aluop = 2'b01; pcsource = 2'b01; end
      S_ADDI:     begin alusrca = 1; alusrcb = 2'b10; end
      S_ORI:      begin alusrca = 1; alusrcb = 2'b10; aluop = 2'b11; end
      S_LUI:      begin alusrca = 1; alusrcb = 2'b11; aluop = 2'b11; end
      S_ALUWB:    regwrite = 1;
      S_JUMP:     begin pcsource = 2'b10; pcen = 1; end
      S_JALWB:    begin regwrite = 1; regdst = 2'b10; end
      S_JR:       begin pcsource = 2'b11; pcen = 1; end
      default:    ;
    endcase
    #1;
    if (s == S_BRANCH) begin
      obs_zero = zero;
      pcen = zero;
      #1;
    end
    if (s == S_FETCH) obs_fetch_addr = bus.addr;
    if (s == S_MEMWRITE) begin
      obs_addr = bus.addr; obs_wdata = bus.wdata; obs_write = bus.write;
    end
    if (bus.write) mem[bus.addr[11:2]] = bus.wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic model_exec(input logic [31:0] ins);
    logic [5:0]  o, fn;
    logic [4:0]  s, t, d;
    logic [31:0] a, b, se, ze, ea, npc;
    o = ins[31:26]; fn = ins[5:0]; s = ins[25:21]; t = ins[20:16]; d = ins[15:11];
    a = m_reg[s]; b = m_reg[t];
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0, ins[15:0]};
    ea = a + se;
    npc = m_pc + 32'd4;
    case (o)
      6'h00: case (fn)
        6'h08: npc = a;
        6'h22: m_reg[d] = a - b;
        6'h24: m_reg[d] = a & b;
        6'h25: m_reg[d] = a | b;
        6'h2a: m_reg[d] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: m_reg[d] = a + b;
      endcase
      6'h23: m_reg[t] = m_mem[ea[11:2]];
      6'h2b: m_mem[ea[11:2]] = b;
      6'h04: if (a == b) npc = m_pc + 32'd4 + (se << 2);
      6'h08: m_reg[t] = a + se;
      6'h0d: m_reg[t] = a | ze;
      6'h0f: m_reg[t] = {ins[15:0], 16'h0};
      6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
      6'h03: begin m_reg[31] = m_pc + 32'd4; npc = {npc[31:28], ins[25:0], 2'b00}; end
      default: ;
    endcase
    m_reg[0] = 32'h0;
    m_pc = npc;
  endtask

  task automatic finish_instr(input logic [31:0] ins);
    ctrl(S_DECODE);
    case (ins[31:26])
      6'h00: if (ins[5:0] == 6'h08) ctrl(S_JR);
             else begin ctrl(S_REXEC); ctrl(S_RWB); end
      6'h23: begin ctrl(S_MEMADR); ctrl(S_MEMREAD); ctrl(S_MEMWB); end
      6'h2b: begin ctrl(S_MEMADR); ctrl(S_MEMWRITE); end
      6'h04: ctrl(S_BRANCH);
      6'h08: begin ctrl(S_ADDI); ctrl(S_ALUWB); end
      6'h0d: begin ctrl(S_ORI); ctrl(S_ALUWB); end
      6'h0f: begin ctrl(S_LUI); ctrl(S_ALUWB); end
      6'h02: ctrl(S_JUMP);
      6'h03: begin ctrl(S_JUMP); ctrl(S_JALWB); end
      default: ;
    endcase
    model_exec(ins);
  endtask

  task automatic run_instr(input logic [31:0] ins);
    mem[m_pc[11:2]] = ins;
    ctrl(S_FETCH);
    finish_instr(ins);
  endtask

  task automatic test_reset();
    reset_n = 0;
    memread = 1; memwrite = 1; alusrca = 0; alusrcb = 2'b00; aluop = 2'b00;
    #1;
    checks++; if (pc_dbg !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc_dbg, 32'h0); end
    checks++; if ({op, funct} !== 12'h0) begin errors++; $display("FAIL reset_op_funct got=%h exp=0", {op, funct}); end
    checks++; if (bus.addr !== 32'h0 || bus.wdata !== 32'h0) begin errors++; $display("FAIL reset_bus got addr=%h wdata=%h exp 0/0", bus.addr, bus.wdata); end
    checks++; if (bus.read !== 1'b1 || bus.write !== 1'b1) begin errors++; $display("FAIL reset_rw got=%b%b exp=11", bus.read, bus.write); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero_pcplusb got=%b exp=1", zero); end
    alusrcb = 2'b01; memread = 0; memwrite = 0;
    #1;
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero_pcplus4 got=%b exp=0", zero); end
    checks++; if (bus.read !== 1'b0 || bus.write !== 1'b0) begin errors++; $display("FAIL reset_rw_low got=%b%b exp=00", bus.read, bus.write); end
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    m_pc = 32'h0;
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_fetch();
    logic [31:0] ins;
    ins = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[0] = ins;
    ctrl(S_FETCH);
    checks++; if (obs_fetch_addr !== 32'h0) begin errors++; $display("FAIL fetch_addr got=%h exp=0", obs_fetch_addr); end
    checks++; if (op !== 6'h08 || funct !== 6'd5) begin errors++; $display("FAIL fetch_ir got op=%h funct=%h exp=08/05", op, funct); end
    checks++; if (pc_dbg !== 32'd4) begin errors++; $display("FAIL fetch_pc got=%h exp=4", pc_dbg); end
    checks++; if (dut.link_q !== 32'd4) begin errors++; $display("FAIL fetch_link got=%h exp=4", dut.link_q); end
    finish_instr(ins);
    checks++; if (dut.rf_q[1] !== 32'd5) begin errors++; $display("FAIL addi_r1 got=%h exp=5", dut.rf_q[1]); end
  endtask

  task automatic test_rtype();
    run_instr(enc_i(6'h08, 5'd0, 5'd2, 16'd7));
    run_instr(enc_r(6'h20, 5'd1, 5'd2, 5'd3));
    checks++; if (dut.rf_q[3] !== 32'd12) begin errors++; $display("FAIL add_r3 got=%h exp=%h", dut.rf_q[3], 32'd12); end
    run_instr(enc_i(6'h08, 5'd0, 5'd1, 16'hFFFF));
    run_instr(enc_i(6'h08, 5'd0, 5'd2, 16'd1));
    run_instr(enc_r(6'h2a, 5'd1, 5'd2, 5'd3));
    checks++; if (dut.rf_q[3] !== 32'd1) begin errors++; $display("FAIL slt_r3 got=%h exp=1", dut.rf_q[3]); end
    checks++; if (pc_dbg !== m_pc) begin errors++; $display("FAIL rtype_pc got=%h exp=%h", pc_dbg, m_pc); end
  endtask

  task automatic test_ori_lui();
    run_instr(enc_i(6'h0d, 5'd0, 5'd4, 16'h8001));
    checks++; if (dut.rf_q[4] !== 32'h0000_8001) begin errors++; $display("FAIL ori_zext got=%h exp=00008001", dut.rf_q[4]); end
    run_instr(enc_i(6'h0f, 5'd0, 5'd5, 16'h1234));
    checks++; if (dut.rf_q[5] !== 32'h1234_0000) begin errors++; $display("FAIL lui got=%h exp=12340000", dut.rf_q[5]); end
  endtask

  task automatic test_memory();
    run_instr(enc_i(6'h08, 5'd0, 5'd1, 16'h0100));
    run_instr(enc_i(6'h08, 5'd0, 5'd6, 16'h0055));
    run_instr(enc_i(6'h2b, 5'd1, 5'd6, 16'hFFFC));
    checks++; if (obs_addr !== 32'h0000_00FC) begin errors++; $display("FAIL sw_addr got=%h exp=000000fc", obs_addr); end
    checks++; if (obs_wdata !== 32'h55 || obs_write !== 1'b1) begin errors++; $display("FAIL sw_data got=%h/%b exp=00000055/1", obs_wdata, obs_write); end
    checks++; if (mem[63] !== m_mem[63]) begin errors++; $display("FAIL sw_mem got=%h exp=%h", mem[63], m_mem[63]); end
    mem[63] = 32'hDEAD_BEEF;
    m_mem[63] = 32'hDEAD_BEEF;
    run_instr(enc_i(6'h23, 5'd1, 5'd7, 16'hFFFC));
    checks++; if (dut.rf_q[7] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw got=%h exp=deadbeef", dut.rf_q[7]); end
  endtask

  task automatic test_branch_jump();
    logic [31:0] pc0;
    run_instr(enc_i(6'h08, 5'd0, 5'd8, 16'd3));
    run_instr(enc_i(6'h08, 5'd0, 5'd9, 16'd3));
    pc0 = m_pc;
    run_instr(enc_i(6'h04, 5'd8, 5'd9, 16'd2));
    checks++; if (obs_zero !== 1'b1) begin errors++; $display("FAIL beq_zero got=%b exp=1", obs_zero); end
    checks++; if (pc_dbg !== pc0 + 32'd12) begin errors++; $display("FAIL beq_taken_pc got=%h exp=%h", pc_dbg, pc0 + 32'd12); end
    pc0 = m_pc;
    run_instr(enc_i(6'h04, 5'd8, 5'd0, 16'd5));
    checks++; if (obs_zero !== 1'b0 || pc_dbg !== pc0 + 32'd4) begin errors++; $display("FAIL beq_not_taken got zero=%b pc=%h exp 0/%h", obs_zero, pc_dbg, pc0 + 32'd4); end
    run_instr(enc_j(6'h02, 26'h100));
    checks++; if (pc_dbg !== 32'h400) begin errors++; $display("FAIL j_pc got=%h exp=00000400", pc_dbg); end
    run_instr(enc_i(6'h08, 5'd0, 5'd31, 16'h0020));
    run_instr(enc_r(6'h08, 5'd31, 5'd0, 5'd0));
    checks++; if (pc_dbg !== 32'h20) begin errors++; $display("FAIL jr_pc got=%h exp=00000020", pc_dbg); end
  endtask

  task automatic test_jal_r0();
    run_instr(enc_i(6'h08, 5'd0, 5'd11, 16'd8));
    run_instr(enc_r(6'h08, 5'd11, 5'd0, 5'd0));
    checks++; if (pc_dbg !== 32'd8) begin errors++; $display("FAIL jr8_pc got=%h exp=8", pc_dbg); end
    run_instr(enc_j(6'h03, 26'h40));
    checks++; if (dut.rf_q[31] !== 32'd12) begin errors++; $display("FAIL jal_link got=%h exp=c", dut.rf_q[31]); end
    checks++; if (pc_dbg !== 32'h100) begin errors++; $display("FAIL jal_pc got=%h exp=00000100", pc_dbg); end
    run_instr(enc_i(6'h08, 5'd0, 5'd0, 16'h0077));
    checks++; if (dut.rf_q[0] !== 32'h0) begin errors++; $display("FAIL r0_write got=%h exp=0", dut.rf_q[0]); end
    run_instr(enc_r(6'h25, 5'd0, 5'd0, 5'd12));
    checks++; if (dut.rf_q[12] !== 32'h0) begin errors++; $display("FAIL r0_read got=%h exp=0", dut.rf_q[12]); end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [4:0]  s, t, d;
    logic [5:0]  fn;
    logic [15:0] im;
    int          k, dst, widx;
    logic [5:0]  fns [5];
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2a;
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 9);
      s = 5'($urandom_range(0, 31));
      t = 5'($urandom_range(0, 31));
      d = 5'($urandom_range(0, 31));
      im = 16'($urandom);
      fn = fns[$urandom_range(0, 4)];
      dst = -1; widx = -1;
      case (k)
        1: begin ins = enc_i(6'h08, s, t, im); dst = int'(t); end
        2: begin ins = enc_i(6'h0d, s, t, im); dst = int'(t); end
        3: begin ins = enc_i(6'h0f, 5'd0, t, im); dst = int'(t); end
        4: begin
          widx = 512 + $urandom_range(0, 511);
          ins = enc_i(6'h23, 5'd0, t, 16'(widx * 4)); dst = int'(t);
        end
        5: begin
          widx = 512 + $urandom_range(0, 511);
          ins = enc_i(6'h2b, 5'd0, t, 16'(widx * 4));
        end
        6: begin
          if ($urandom_range(0, 1) == 1) t = s;
          ins = enc_i(6'h04, s, t, 16'($urandom_range(0, 3)));
        end
        default: begin ins = enc_r(fn, s, t, d); dst = int'(d); end
      endcase
      run_instr(ins);
      checks++; if (pc_dbg !== m_pc) begin errors++; $display("FAIL rand_pc n=%0d got=%h exp=%h", n, pc_dbg, m_pc); end
      if (dst >= 0) begin
        checks++; if (dut.rf_q[dst] !== m_reg[dst]) begin errors++; $display("FAIL rand_reg n=%0d r%0d got=%h exp=%h", n, dst, dut.rf_q[dst], m_reg[dst]); end
      end else if (k == 5) begin
        checks++; if (mem[widx] !== m_mem[widx]) begin errors++; $display("FAIL rand_sw n=%0d got=%h exp=%h", n, mem[widx], m_mem[widx]); end
      end
    end
    for (int r = 0; r < 32; r++) begin
      checks++; if (dut.rf_q[r] !== m_reg[r]) begin errors++; $display("FAIL rand_final r%0d got=%h exp=%h", r, dut.rf_q[r], m_reg[r]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ins;
    ins = enc_i(6'h23, 5'd0, 5'd13, 16'h0804);
    mem[m_pc[11:2]] = ins;
    ctrl(S_FETCH);
    ctrl(S_DECODE);
    ctrl(S_MEMADR);
    reset_n = 0;
    #1;
    checks++; if (pc_dbg !== 32'h0 || op !== 6'h0 || bus.addr !== 32'h0) begin errors++; $display("FAIL midreset_state got pc=%h op=%h addr=%h exp 0/0/0", pc_dbg, op, bus.addr); end
    checks++; if (dut.rf_q[31] !== 32'h0) begin errors++; $display("FAIL midreset_rf got=%h exp=0", dut.rf_q[31]); end
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    m_pc = 32'h0;
    @(negedge clk);
    reset_n = 1;
    run_instr(enc_i(6'h08, 5'd0, 5'd1, 16'd9));
    checks++; if (pc_dbg !== 32'd4 || dut.rf_q[1] !== 32'd9) begin errors++; $display("FAIL post_reset_fetch got pc=%h r1=%h exp 4/9", pc_dbg, dut.rf_q[1]); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      m_mem[i] = mem[i];
    end
    test_reset();
    test_fetch();
    test_rtype();
    test_ori_lui();
    test_memory();
    test_branch_jump();
    test_jal_r0();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
